// File: rtl/priority_encoder8to3.sv
// Sequential 8-to-3 priority encoder: latches event pulses into a pending vector and
// presents the highest pending line number over a valid/ack handshake.
module priority_encoder8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [7:0] req,
  input  logic       ack,
  input  logic       clr_ovf,
  output logic       i0,
  output logic       i1,
  output logic       i2,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t     state_r, state_next_s;
  logic [2:0] code_r, code_next_s;
  logic [7:0] pending_r, pending_next_s;
  logic [7:0] clr_s, captured_s, remain_s;
  logic       overflow_r, overflow_next_s, dup_s;

  // Highest set index, line 7 wins.
  function automatic logic [2:0] highest(input logic [7:0] v);
    logic [2:0] idx;
    casez (v)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      default:     idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] c);
    return 8'd1 << c;
  endfunction

  // Acknowledge clear mask, event capture and duplicate-event detection.
  always_comb begin
    clr_s = 8'h00;
    if (state_r == PRESENT && ack) begin
      clr_s = onehot(code_r);
    end else begin
      clr_s = 8'h00;
    end
    captured_s     = req & {8{E}};
    remain_s       = pending_r & ~clr_s;
    pending_next_s = remain_s | captured_s;
    dup_s          = |(captured_s & remain_s);
  end

  // State register together with the registered datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      code_r     <= 3'b000;
      pending_r  <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      code_r     <= code_next_s;
      pending_r  <= pending_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  // Next-state logic; selection always looks at the registered pending vector.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pending_r != 8'h00) state_next_s = PRESENT;
        else                    state_next_s = IDLE;
      end
      PRESENT: begin
        if (ack && remain_s == 8'h00) state_next_s = IDLE;
        else                          state_next_s = PRESENT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Code and overflow updates; an ack with other lines pending loads the next code at once.
  always_comb begin
    code_next_s     = code_r;
    overflow_next_s = overflow_r;
    case (state_r)
      IDLE: begin
        if (pending_r != 8'h00) code_next_s = highest(pending_r);
        else                    code_next_s = code_r;
      end
      PRESENT: begin
        if (ack && remain_s != 8'h00) code_next_s = highest(remain_s);
        else                          code_next_s = code_r;
      end
      default: code_next_s = code_r;
    endcase
    if (dup_s)        overflow_next_s = 1'b1;
    else if (clr_ovf) overflow_next_s = 1'b0;
    else              overflow_next_s = overflow_r;
  end

  assign i0       = code_r[2];
  assign i1       = code_r[1];
  assign i2       = code_r[0];
  assign valid    = (state_r == PRESENT);
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule
